// File: rtl/sccb_cfg_scheduler.sv
// sccb_cfg_scheduler
//   Walks the camera configuration ROM at boot and turns every entry into a
//   single-register write on the byte-level SCCB write master.  ROM word
//   16'hFFF0 inserts a fixed wait, 16'hFFFF (or running off the end of the ROM)
//   finishes the boot.  A NACKed write is re-issued up to MAX_RETRY times; if
//   it still fails, the boot aborts into FAIL.  After a successful boot the same
//   master is lent to a run-time requester for one-off register writes.  A new
//   start always wins over a pending user write.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin / re-run the boot sequence (IDLE, READY, FAIL)
//   rom_addr / rom_data   config ROM port, registered read (1-cycle latency)
//   m_valid .. m_val      write command to the SCCB master (valid/ready)
//   m_done / m_nack       completion pulse of the master, NACK flag with it
//   user_req/reg/val      run-time write request, held until user_ack
//   user_ack / user_err   1-cycle completion pulse, failure flag with it
//   busy / done / error   boot status
module sccb_cfg_scheduler #(
  parameter logic [7:0] DEV_ADDR     = 8'h42,
  parameter int         ROM_DEPTH    = 76,
  parameter int         MAX_RETRY    = 3,
  parameter int         DELAY_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_dev,
  output logic [7:0]  m_reg,
  output logic [7:0]  m_val,
  input  logic        m_done,
  input  logic        m_nack,
  input  logic        user_req,
  input  logic [7:0]  user_reg,
  input  logic [7:0]  user_val,
  output logic        user_ack,
  output logic        user_err,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [7:0]    IDX_END    = 8'(ROM_DEPTH);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_WAIT      = 4'd2,
    S_DECODE    = 4'd3,
    S_ISSUE     = 4'd4,
    S_WAIT_DONE = 4'd5,
    S_DELAY     = 4'd6,
    S_READY     = 4'd7,
    S_U_ISSUE   = 4'd8,
    S_U_WAIT    = 4'd9,
    S_FAIL      = 4'd10
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [7:0]    rom_addr_q, rom_addr_d;
  logic          m_valid_q, m_valid_d;
  logic [7:0]    m_reg_q, m_reg_d;
  logic [7:0]    m_val_q, m_val_d;
  logic          user_ack_q, user_ack_d;
  logic          user_err_q, user_err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          restart_s;

  // The entry index stops at ROM_DEPTH so that it keeps acting as an end marker.
  function automatic logic [7:0] idx_next(input logic [7:0] idx);
    if (idx == IDX_END) begin
      return idx;
    end else begin
      return idx + 8'd1;
    end
  endfunction

  // start is only honoured where the boot is not running; it beats user_req.
  assign restart_s = start && ((state_q == S_IDLE) || (state_q == S_READY) ||
                               (state_q == S_FAIL));

  // Next-state and next-output logic of the scheduler.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    dly_d      = dly_q;
    rom_addr_d = rom_addr_q;
    m_reg_d    = m_reg_q;
    m_val_d    = m_val_q;
    user_ack_d = 1'b0;
    user_err_d = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;

    if (restart_s) begin
      state_d = S_FETCH;
      idx_d   = 8'd0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_FETCH: begin
          rom_addr_d = idx_q;
          state_d    = S_WAIT;
        end
        // Covers the registered ROM read latency.
        S_WAIT: state_d = S_DECODE;
        S_DECODE: begin
          if ((idx_q == IDX_END) || (rom_data == 16'hFFFF)) begin
            state_d = S_READY;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (rom_data == 16'hFFF0) begin
            state_d = S_DELAY;
            dly_d   = '0;
          end else begin
            m_reg_d = rom_data[15:8];
            m_val_d = rom_data[7:0];
            retry_d = '0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (m_valid_q && m_ready) begin
            state_d = S_WAIT_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_WAIT_DONE: begin
          if (!m_done) begin
            state_d = S_WAIT_DONE;
          end else if (!m_nack) begin
            idx_d   = idx_next(idx_q);
            state_d = S_FETCH;
          end else if (retry_q == RETRY_LAST) begin
            state_d = S_FAIL;
            error_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
          end else begin
            retry_d = retry_q + {{(RW-1){1'b0}}, 1'b1};
            state_d = S_ISSUE;
          end
        end
        S_DELAY: begin
          if (dly_q == DELAY_LAST) begin
            idx_d   = idx_next(idx_q);
            state_d = S_FETCH;
          end else begin
            dly_d = dly_q + {{(DW-1){1'b0}}, 1'b1};
          end
        end
        S_READY: begin
          if (user_req) begin
            m_reg_d = user_reg;
            m_val_d = user_val;
            retry_d = '0;
            state_d = S_U_ISSUE;
          end else begin
            state_d = S_READY;
          end
        end
        S_U_ISSUE: begin
          if (m_valid_q && m_ready) begin
            state_d = S_U_WAIT;
          end else begin
            state_d = S_U_ISSUE;
          end
        end
        // The final attempt reports its own NACK; a user failure never sets error.
        S_U_WAIT: begin
          if (!m_done) begin
            state_d = S_U_WAIT;
          end else if (!m_nack || (retry_q == RETRY_LAST)) begin
            user_ack_d = 1'b1;
            user_err_d = m_nack;
            state_d    = S_READY;
          end else begin
            retry_d = retry_q + {{(RW-1){1'b0}}, 1'b1};
            state_d = S_U_ISSUE;
          end
        end
        S_FAIL: state_d = S_FAIL;
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      endcase
    end

    // Valid is a flop that is high exactly while the FSM sits in an issue state.
    m_valid_d = (state_d == S_ISSUE) || (state_d == S_U_ISSUE);
  end

  // State and datapath registers; the asynchronous clear idles every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 8'd0;
      retry_q    <= '0;
      dly_q      <= '0;
      rom_addr_q <= 8'd0;
      m_valid_q  <= 1'b0;
      m_reg_q    <= 8'd0;
      m_val_q    <= 8'd0;
      user_ack_q <= 1'b0;
      user_err_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      dly_q      <= dly_d;
      rom_addr_q <= rom_addr_d;
      m_valid_q  <= m_valid_d;
      m_reg_q    <= m_reg_d;
      m_val_q    <= m_val_d;
      user_ack_q <= user_ack_d;
      user_err_q <= user_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign m_valid  = m_valid_q;
  assign m_dev    = DEV_ADDR;
  assign m_reg    = m_reg_q;
  assign m_val    = m_val_q;
  assign user_ack = user_ack_q;
  assign user_err = user_err_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_sccb_cfg_scheduler.sv
// Bench for sccb_cfg_scheduler: ROM model, SCCB master model with programmable
// NACKs and backpressure, and a command scoreboard fed from the test sequence.
module tb_sccb_cfg_scheduler;

  localparam int MAX_RETRY    = 3;
  localparam int DELAY_CYCLES = 50;
  localparam int DONE_LAT     = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_dev;
  logic [7:0]  m_reg;
  logic [7:0]  m_val;
  logic        m_done = 1'b0;
  logic        m_nack = 1'b0;
  logic        user_req = 1'b0;
  logic [7:0]  user_reg = 8'h00;
  logic [7:0]  user_val = 8'h00;
  logic        user_ack;
  logic        user_err;
  logic        busy;
  logic        done;
  logic        error;

  sccb_cfg_scheduler #(
    .DEV_ADDR    (8'h42),
    .ROM_DEPTH   (8),
    .MAX_RETRY   (MAX_RETRY),
    .DELAY_CYCLES(DELAY_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_dev(m_dev),
    .m_reg(m_reg), .m_val(m_val), .m_done(m_done), .m_nack(m_nack),
    .user_req(user_req), .user_reg(user_reg), .user_val(user_val),
    .user_ack(user_ack), .user_err(user_err),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read config ROM; addresses past the table read as end marker.
  logic [15:0] rom_mem [8];
  always @(posedge clk) rom_data <= (rom_addr < 8'd8) ? rom_mem[rom_addr[2:0]] : 16'hFFFF;

  // SCCB master model: works on the falling edge, logs every accepted command.
  logic [7:0] acc_reg [256];
  logic [7:0] acc_val [256];
  int         acc_cyc [256];
  int         n_acc = 0;
  int         nack_until = 0;
  int         stall_until = 0;
  int         done_cyc = 0;
  int         dly = 0;
  logic       pend = 1'b0;
  logic       pend_nack = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ready = 1'b0;
      m_done  = 1'b0;
      m_nack  = 1'b0;
      pend    = 1'b0;
    end else begin
      m_done = 1'b0;
      m_nack = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          m_done   = 1'b1;
          m_nack   = pend_nack;
          pend     = 1'b0;
          done_cyc = cyc;
        end else begin
          dly = dly - 1;
        end
      end
      m_ready = (cyc >= stall_until);
      if (m_valid && m_ready && (n_acc < 256)) begin
        acc_reg[n_acc] = m_reg;
        acc_val[n_acc] = m_val;
        acc_cyc[n_acc] = cyc;
        pend_nack      = (n_acc < nack_until);
        n_acc          = n_acc + 1;
        pend           = 1'b1;
        dly            = DONE_LAT - 1;
      end
    end
  end

  // ---------------- scoreboard and checking ----------------
  int          checks = 0;
  int          errors = 0;
  int          rd = 0;
  int          ack_cnt = 0;
  int          ack_cyc = 0;
  logic        ack_err = 1'b0;
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample #1 after the rising edge, record acks, drain the command log.
  task automatic step();
    logic [15:0] e;
    @(posedge clk);
    #1;
    if (user_ack) begin
      ack_cnt++;
      ack_err = user_err;
      ack_cyc = cyc;
    end
    while (rd < n_acc) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd: got 0x%0h, expected none", {acc_reg[rd], acc_val[rd]});
      end else begin
        e = exp_q.pop_front();
        check("cmd", {16'h0000, acc_reg[rd], acc_val[rd]}, {16'h0000, e});
      end
      rd++;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_boot();
    exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1101);
  endtask

  typedef struct {
    logic [7:0] rg;
    logic [7:0] val;
    int         nacks;
    logic       exp_err;
  } uvec_t;

  uvec_t tbl [4];
  int    n0, a0, attempts;
  logic  seen, flag;

  initial begin
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h1101; rom_mem[3] = 16'hFFFF;
    rom_mem[4] = 16'hFFFF; rom_mem[5] = 16'hFFFF; rom_mem[6] = 16'hFFFF; rom_mem[7] = 16'hFFFF;
    tbl[0] = '{8'h10, 8'h40, 0, 1'b0};
    tbl[1] = '{8'h3B, 8'h0A, 1, 1'b0};
    tbl[2] = '{8'h1E, 8'h27, 4, 1'b1};
    tbl[3] = '{8'h00, 8'hFF, 3, 1'b0};

    // Reset state
    repeat (3) step();
    check("rst_valid", m_valid, 1'b0);
    check("rst_dev", m_dev, 8'h42);
    check("rst_status", {busy, done, error, user_ack, user_err}, 5'b00000);
    check("rst_regs", {rom_addr, m_reg, m_val}, 24'h000000);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_no_start", {busy, m_valid}, 2'b00);

    // Boot sequence with a delay entry
    push_boot();
    n0 = n_acc;
    pulse_start();
    check("boot_busy", {busy, done}, 2'b10);
    for (int k = 0; k < 400 && !done; k++) step();
    check("boot_done", {busy, done, error}, 3'b010);
    check("boot_cmds", n_acc - n0, 2);
    check("boot_gap", (acc_cyc[n0 + 1] - acc_cyc[n0]) >= (DONE_LAT + DELAY_CYCLES), 1'b1);

    // NACK retry: two NACKs on entry 0, then success
    nack_until = n_acc + 2;
    repeat (3) exp_q.push_back(16'h1280);
    exp_q.push_back(16'h1101);
    n0 = n_acc;
    pulse_start();
    for (int k = 0; k < 600 && !done; k++) step();
    check("retry_done", {done, error}, 2'b10);
    check("retry_cmds", n_acc - n0, 4);

    // Run-time writes, table driven
    for (int i = 0; i < 4; i++) begin
      nack_until = n_acc + tbl[i].nacks;
      attempts = (tbl[i].nacks > MAX_RETRY) ? MAX_RETRY + 1 : tbl[i].nacks + 1;
      for (int j = 0; j < attempts; j++) exp_q.push_back({tbl[i].rg, tbl[i].val});
      a0 = ack_cnt;
      n0 = n_acc;
      user_reg = tbl[i].rg;
      user_val = tbl[i].val;
      user_req = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 2 && !seen; k++) begin
        step();
        seen = m_valid;
      end
      check("u_valid_latency", seen, 1'b1);
      for (int k = 0; k < 400 && ack_cnt == a0; k++) step();
      user_req = 1'b0;
      check("u_ack", ack_cnt - a0, 1);
      check("u_err", ack_err, tbl[i].exp_err);
      check("u_ack_after_done", ack_cyc - done_cyc, 1);
      check("u_attempts", n_acc - n0, attempts);
      check("u_status", {done, error}, 2'b10);
      step();
      check("u_ack_pulse", user_ack, 1'b0);
    end

    // Backpressure: command must hold while m_ready is low
    exp_q.push_back(16'h2A55);
    stall_until = cyc + 10;
    user_reg = 8'h2A;
    user_val = 8'h55;
    user_req = 1'b1;
    a0 = ack_cnt;
    for (int k = 0; k < 3 && !m_valid; k++) step();
    n0 = n_acc;
    flag = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      flag = flag && m_valid && (m_reg == 8'h2A) && (m_val == 8'h55);
    end
    check("bp_stable", flag, 1'b1);
    check("bp_no_accept", n_acc - n0, 0);
    for (int k = 0; k < 200 && ack_cnt == a0; k++) step();
    user_req = 1'b0;
    check("bp_ack", {ack_cnt - a0 == 1, ack_err}, 2'b10);

    // user_req raised mid-boot waits for the boot to finish
    push_boot();
    exp_q.push_back(16'h1040);
    a0 = ack_cnt;
    pulse_start();
    repeat (5) step();
    user_reg = 8'h10;
    user_val = 8'h40;
    user_req = 1'b1;
    for (int k = 0; k < 400 && !done; k++) step();
    check("arb_no_early_ack", {done, ack_cnt - a0 == 0}, 2'b11);
    for (int k = 0; k < 200 && ack_cnt == a0; k++) step();
    user_req = 1'b0;
    check("arb_ack", ack_cnt - a0, 1);

    // start and user_req together in READY: boot runs first
    push_boot();
    exp_q.push_back(16'h3344);
    a0 = ack_cnt;
    n0 = n_acc;
    user_reg = 8'h33;
    user_val = 8'h44;
    user_req = 1'b1;
    pulse_start();
    check("simul_boot_first", {busy, done}, 2'b10);
    for (int k = 0; k < 600 && ack_cnt == a0; k++) step();
    user_req = 1'b0;
    check("simul_ack", ack_cnt - a0, 1);
    check("simul_cmds", n_acc - n0, 3);

    // Persistent NACK -> FAIL
    nack_until = n_acc + 4;
    repeat (4) exp_q.push_back(16'h1280);
    n0 = n_acc;
    pulse_start();
    for (int k = 0; k < 400 && !error; k++) step();
    check("fail_status", {error, done, busy}, 3'b100);
    check("fail_cmds", n_acc - n0, 4);
    a0 = ack_cnt;
    n0 = n_acc;
    user_reg = 8'h10;
    user_val = 8'h40;
    user_req = 1'b1;
    repeat (60) step();
    user_req = 1'b0;
    check("fail_no_ack", ack_cnt - a0, 0);
    check("fail_no_cmd", n_acc - n0, 0);
    push_boot();
    pulse_start();
    for (int k = 0; k < 400 && !done; k++) step();
    check("fail_rerun", {done, error}, 2'b10);

    // Reset while waiting for completion of entry 2
    push_boot();
    n0 = n_acc;
    pulse_start();
    for (int k = 0; k < 300 && n_acc < n0 + 2; k++) step();
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_status", {busy, done, error, m_valid, user_ack}, 5'b00000);
    check("rst_mid_regs", {rom_addr, m_reg, m_val}, 24'h000000);
    repeat (2) step();
    rst_n = 1'b1;
    n0 = n_acc;
    flag = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      flag = flag || m_valid || busy;
    end
    check("rst_quiet", {flag, n_acc - n0 == 0}, 2'b01);

    // Reset while a command is being offered drops m_valid at once
    stall_until = cyc + 1000;
    pulse_start();
    for (int k = 0; k < 10 && !m_valid; k++) step();
    check("rst_valid_pre", m_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_valid_drop", m_valid, 1'b0);
    step();
    stall_until = cyc;
    rst_n = 1'b1;
    repeat (5) step();
    check("rst_valid_idle", {m_valid, busy}, 2'b00);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_cfg_scheduler.md
Name: sccb_cfg_scheduler

Overview:
- Sequences OV7670 boot-time register configuration from the config ROM into a byte-level SCCB write master.
- After boot, arbitrates the same SCCB master for run-time single-register writes (exposure, gain, mirror) from a user requester.
- Adds delay entries, end markers, NACK retry and a fail state.
- Sits between camera_config_ROM and the SCCB write engine; boot traffic always has priority.

Parameters:
- DEV_ADDR, 8'h42: SCCB write device address driven on m_dev.
- ROM_DEPTH, 76: number of ROM entries. Reaching this index acts as an end marker.
- MAX_RETRY, 3: re-issues of a NACKed write before giving up, so MAX_RETRY+1 attempts in total.
- DELAY_CYCLES, 1000000: clk cycles waited for a delay entry (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- start  in  1  level/pulse; starts or re-runs the boot sequence
- rom_addr  out  8  config ROM address
- rom_data  in  16  ROM word {reg[15:8], val[7:0]}; 1-cycle registered read latency
- m_valid  out  1  write command valid to SCCB master
- m_ready  in  1  master accepts command when m_valid&&m_ready
- m_dev  out  8  device address (constant DEV_ADDR)
- m_reg  out  8  register address
- m_val  out  8  register data
- m_done  in  1  1-cycle pulse; transaction finished
- m_nack  in  1  valid only with m_done; 1 = any byte NACKed
- user_req  in  1  run-time write request; held until user_ack
- user_reg  in  8  run-time register address; stable while user_req
- user_val  in  8  run-time register data; stable while user_req
- user_ack  out  1  1-cycle pulse; user write finished
- user_err  out  1  qualified by user_ack; write failed after retries
- busy  out  1  boot sequence in progress
- done  out  1  boot completed successfully
- error  out  1  boot aborted (persistent NACK)

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. All outputs are 0 at reset, except m_dev, which is tied to DEV_ADDR. State goes to IDLE and all counters clear.
- Reset mid-transaction drops m_valid immediately. The SCCB master shares rst_n.
- States: IDLE, FETCH, WAIT, DECODE, ISSUE, WAIT_DONE, DELAY, READY, U_ISSUE, U_WAIT, FAIL.
- IDLE:
  - start=1 → FETCH, entry index=0, busy=1, done=0, error=0.
- FETCH:
  - Drive rom_addr=index → WAIT.
- WAIT:
  - One cycle → DECODE.
  - rom_data is sampled only in DECODE, i.e. 2 cycles after the rom_addr update.
- DECODE:
  - index==ROM_DEPTH, or word 16'hFFFF (end marker) → READY, busy=0, done=1.
  - Word 16'hFFF0 → DELAY, delay counter=0.
  - Otherwise latch m_reg/m_val, retry counter=0 → ISSUE.
- ISSUE:
  - m_valid=1.
  - m_reg/m_val stay stable until the handshake; no timeout on m_ready.
  - On m_valid&&m_ready: m_valid=0 → WAIT_DONE.
- WAIT_DONE:
  - m_done&&!m_nack → index+1 → FETCH.
  - m_done&&m_nack&&retry<MAX_RETRY → retry+1 → ISSUE with the same reg/val.
  - m_done&&m_nack&&retry==MAX_RETRY → FAIL.
- DELAY:
  - Count to DELAY_CYCLES-1, then index+1 → FETCH.
  - m_valid=0 throughout.
- FAIL:
  - error=1, busy=0, done=0; rom_addr frozen.
  - user requests are not serviced.
  - start → IDLE path (re-run boot).
- READY:
  - done=1.
  - start has priority: if start → re-run boot, exactly as from IDLE.
  - Else if user_req → latch user_reg/user_val, retry=0 → U_ISSUE.
  - Simultaneous start and user_req: boot wins; user_req stays pending and is serviced once READY is re-entered.
- U_ISSUE / U_WAIT:
  - Same handshake and retry rules as ISSUE / WAIT_DONE.
  - Completion: user_ack=1 for 1 cycle, user_err=m_nack of the final attempt → READY.
  - A failed user write does not set error.
- user_req while not in READY: ignored (no ack) until READY is entered.
- Widths:
  - Entry index: 8 bits, saturates at ROM_DEPTH.
  - Retry counter: $clog2(MAX_RETRY+1) bits.
  - Delay counter: $clog2(DELAY_CYCLES) bits.
- m_done outside WAIT_DONE/U_WAIT is ignored.

Test Plan:
- Boot sequence:
  - Stimulus: ROM {1280, FFF0, 1101, FFFF}, DELAY_CYCLES=50, m_ready=1, master returns m_done 20 cycles after accept; start pulse.
  - Required: m_valid with reg 12/val 80; ≥50 cycles with no m_valid; then 11/01; then done=1, busy=0, only 2 commands total.
- NACK retry:
  - Stimulus: master NACKs entry 0 twice, MAX_RETRY=3.
  - Required: 3 accepts of 12/80, then advance; error=0, done=1.
- Persistent NACK:
  - Stimulus: 4 NACKs on entry 0.
  - Required: FAIL, error=1, done=0, busy=0; no further m_valid; a later user_req gets no ack.
- User write:
  - Stimulus: after done, user_req reg 10/val 40.
  - Required: m_valid with 10/40 within 2 cycles; user_ack 1-cycle pulse one cycle after m_done; user_err=0.
  - Variant with NACK on all 4 attempts: user_ack with user_err=1, error=0.
- Arbitration:
  - Stimulus: user_req raised mid-boot.
  - Required: no ack until done=1, then serviced.
  - Stimulus: start and user_req together in READY.
  - Required: ROM entry 0 issued first; user write follows the rerun boot.
- Backpressure and reset:
  - Stimulus: m_ready held 0 for 5 cycles.
  - Required: m_valid/m_reg/m_val stable throughout.
  - Stimulus: rst_n asserted in WAIT_DONE.
  - Required: all outputs return to reset values the same cycle; after release, no activity until start.
